// File: rtl/pipeline_run_controller_if.sv
// Command/status bundle between the debug unit and the pipeline run controller.
// master = controller side (drives enables and status), slave = debug/pipeline side.
interface pipeline_run_controller_if #(
  parameter int CNT_W = 32
);
  logic             i_cmd_valid;
  logic [1:0]       i_cmd;
  logic             o_cmd_ready;
  logic             i_halt;
  logic             o_pipe_en;
  logic             o_pipe_clear;
  logic             o_step_done;
  logic             o_done;
  logic             o_timeout;
  logic             o_cmd_err;
  logic [CNT_W-1:0] o_cycle_cnt;

  modport master (
    input  i_cmd_valid, i_cmd, i_halt,
    output o_cmd_ready, o_pipe_en, o_pipe_clear, o_step_done,
           o_done, o_timeout, o_cmd_err, o_cycle_cnt
  );

  modport slave (
    output i_cmd_valid, i_cmd, i_halt,
    input  o_cmd_ready, o_pipe_en, o_pipe_clear, o_step_done,
           o_done, o_timeout, o_cmd_err, o_cycle_cnt
  );
endinterface

// File: rtl/pipeline_run_controller.sv
// Run/step/drain sequencer for the 5-stage pipeline; optional watchdog via WATCHDOG_EN.
// All outputs registered: commands act the cycle after acceptance; commands held off outside IDLE/DONE.
module pipeline_run_controller #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int WDOG_LIMIT   = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_run_controller_if.master   bus
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             clear_q, clear_d;
  logic             step_done_q, step_done_d;
  logic             done_q, done_d;
  logic             cmd_err_q, cmd_err_d;
  logic             accept;
`ifdef WATCHDOG_EN
  logic             timeout_q, timeout_d;
`endif

  assign accept = bus.i_cmd_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    clear_d     = 1'b0;
    step_done_d = 1'b0;
    cmd_err_d   = 1'b0;
    cnt_d       = (en_q && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef WATCHDOG_EN
    timeout_d   = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.i_cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_CLEAR: begin
              clear_d = 1'b1;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // halt has priority over the watchdog when both land in the same cycle
        if (bus.i_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end
`ifdef WATCHDOG_EN
        else if (cnt_q >= CNT_W'(WDOG_LIMIT)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
`endif
      end
      S_STEP: begin
        if (bus.i_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          state_d     = S_IDLE;
          step_done_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      S_DONE: begin
        if (accept) begin
          case (bus.i_cmd)
            CMD_CLEAR: begin
              state_d = S_IDLE;
              clear_d = 1'b1;
              cnt_d   = '0;
`ifdef WATCHDOG_EN
              timeout_d = 1'b0;
`endif
            end
            CMD_RUN, CMD_STEP: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
    en_d    = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_q     <= 4'd0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      ready_q     <= 1'b1;
      clear_q     <= 1'b0;
      step_done_q <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
`ifdef WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      clear_q     <= clear_d;
      step_done_q <= step_done_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
`ifdef WATCHDOG_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.o_cmd_ready  = ready_q;
  assign bus.o_pipe_en    = en_q;
  assign bus.o_pipe_clear = clear_q;
  assign bus.o_step_done  = step_done_q;
  assign bus.o_done       = done_q;
  assign bus.o_cmd_err    = cmd_err_q;
  assign bus.o_cycle_cnt  = cnt_q;
`ifdef WATCHDOG_EN
  assign bus.o_timeout    = timeout_q;
`else
  assign bus.o_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_run_controller.sv
// Directed bench for pipeline_run_controller: run/step/drain/done/clear sequences,
// plus watchdog cases when WATCHDOG_EN is defined (WDOG_LIMIT=20).
module tb_pipeline_run_controller;
  localparam int CNT_W = 32;
  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, CLR = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_en, gap;
  logic saw_sd;

  always #5 clk = ~clk;

  pipeline_run_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_run_controller #(
    .CNT_W(CNT_W), .DRAIN_CYCLES(3), .WDOG_LIMIT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer a command for one accepted cycle; returns on the negedge after acceptance.
  task automatic send_cmd(input logic [1:0] c);
    int w = 0;
    while (!bus.o_cmd_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check_val("cmd_ready_wait", 64'(bus.o_cmd_ready), 64'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = c;
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = NOP;
  endtask

  // Watch until o_done; raise i_halt on the halt_idx-th enabled cycle or when cnt==halt_cnt.
  task automatic run_watch(input int halt_idx, input int halt_cnt,
                           output int en_cnt, output int done_gap, output logic sd);
    int last = -1;
    int first_done = -1;
    en_cnt = 0;
    sd = 1'b0;
    for (int k = 0; k < 200; k++) begin
      bus.i_halt = 1'b0;
      if (bus.o_pipe_en) begin
        en_cnt++;
        last = k;
      end
      if (bus.o_step_done) sd = 1'b1;
      if (bus.o_done) begin
        first_done = k;
        break;
      end
      if (bus.o_pipe_en && (en_cnt == halt_idx ||
          (halt_cnt >= 0 && bus.o_cycle_cnt == CNT_W'(halt_cnt))))
        bus.i_halt = 1'b1;
      tick();
    end
    bus.i_halt = 1'b0;
    if (first_done < 0) check_val("done_wait", 64'(bus.o_done), 64'd1);
    done_gap = first_done - last;
  endtask

  initial begin
    rst = 1'b1;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd       = RUN;
    bus.i_halt      = 1'b1;
    tick();
    tick();
    check_val("rst_en",    64'(bus.o_pipe_en),    64'd0);
    check_val("rst_ready", 64'(bus.o_cmd_ready),  64'd1);
    check_val("rst_clear", 64'(bus.o_pipe_clear), 64'd0);
    check_val("rst_sd",    64'(bus.o_step_done),  64'd0);
    check_val("rst_done",  64'(bus.o_done),       64'd0);
    check_val("rst_to",    64'(bus.o_timeout),    64'd0);
    check_val("rst_err",   64'(bus.o_cmd_err),    64'd0);
    check_val("rst_cnt",   64'(bus.o_cycle_cnt),  64'd0);
    rst = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd       = NOP;
    tick();
    check_val("idle_en",   64'(bus.o_pipe_en),    64'd0);
    tick();
    check_val("halt_idle_done", 64'(bus.o_done),  64'd0);
    bus.i_halt = 1'b0;

    send_cmd(NOP);
    check_val("nop_en",    64'(bus.o_pipe_en),    64'd0);
    check_val("nop_ready", 64'(bus.o_cmd_ready),  64'd1);

    for (int s = 0; s < 3; s++) begin
      send_cmd(STEP);
      check_val("step_en",    64'(bus.o_pipe_en),   64'd1);
      check_val("step_ready", 64'(bus.o_cmd_ready), 64'd0);
      check_val("step_sd0",   64'(bus.o_step_done), 64'd0);
      tick();
      check_val("step_en_off", 64'(bus.o_pipe_en),  64'd0);
      check_val("step_sd",     64'(bus.o_step_done), 64'd1);
      tick();
      check_val("step_sd_end", 64'(bus.o_step_done), 64'd0);
    end
    check_val("step_cnt", 64'(bus.o_cycle_cnt), 64'd3);

    send_cmd(CLR);
    check_val("clr_pulse", 64'(bus.o_pipe_clear), 64'd1);
    check_val("clr_cnt",   64'(bus.o_cycle_cnt),  64'd0);
    tick();
    check_val("clr_pulse_end", 64'(bus.o_pipe_clear), 64'd0);

    send_cmd(STEP);
    run_watch(1, -1, n_en, gap, saw_sd);
    check_val("sh_en_cycles", 64'(n_en), 64'd4);
    check_val("sh_no_sd",     64'(saw_sd), 64'd0);
    check_val("sh_cnt",       64'(bus.o_cycle_cnt), 64'd4);
    check_val("sh_gap",       64'(gap), 64'd1);

    send_cmd(RUN);
    check_val("err_pulse",  64'(bus.o_cmd_err), 64'd1);
    check_val("err_en",     64'(bus.o_pipe_en), 64'd0);
    check_val("err_done",   64'(bus.o_done),    64'd1);
    tick();
    check_val("err_end",    64'(bus.o_cmd_err), 64'd0);
    check_val("err_en2",    64'(bus.o_pipe_en), 64'd0);
    send_cmd(CLR);
    check_val("dclr_pulse", 64'(bus.o_pipe_clear), 64'd1);
    check_val("dclr_done",  64'(bus.o_done),       64'd0);
    check_val("dclr_cnt",   64'(bus.o_cycle_cnt),  64'd0);
    check_val("dclr_ready", 64'(bus.o_cmd_ready),  64'd1);

    send_cmd(RUN);
    run_watch(10, -1, n_en, gap, saw_sd);
    check_val("run_en_cycles", 64'(n_en), 64'd13);
    check_val("run_cnt",       64'(bus.o_cycle_cnt), 64'd13);
    check_val("run_gap",       64'(gap), 64'd1);
    check_val("run_en_off",    64'(bus.o_pipe_en), 64'd0);
    check_val("run_to",        64'(bus.o_timeout), 64'd0);
    send_cmd(CLR);

`ifdef WATCHDOG_EN
    send_cmd(RUN);
    run_watch(-1, -1, n_en, gap, saw_sd);
    check_val("wd_en_cycles", 64'(n_en), 64'd21);
    check_val("wd_cnt",       64'(bus.o_cycle_cnt), 64'd21);
    check_val("wd_to",        64'(bus.o_timeout), 64'd1);
    tick();
    check_val("wd_to_hold",   64'(bus.o_timeout), 64'd1);
    send_cmd(CLR);
    check_val("wd_to_clr",    64'(bus.o_timeout), 64'd0);
    send_cmd(RUN);
    run_watch(-1, 20, n_en, gap, saw_sd);
    check_val("wdh_en_cycles", 64'(n_en), 64'd24);
    check_val("wdh_cnt",       64'(bus.o_cycle_cnt), 64'd24);
    check_val("wdh_to",        64'(bus.o_timeout), 64'd0);
    send_cmd(CLR);
`else
    send_cmd(RUN);
    run_watch(30, -1, n_en, gap, saw_sd);
    check_val("nowd_en_cycles", 64'(n_en), 64'd33);
    check_val("nowd_to",        64'(bus.o_timeout), 64'd0);
    send_cmd(CLR);
`endif

    send_cmd(RUN);
    bus.i_halt = 1'b1;
    tick();
    bus.i_halt = 1'b0;
    check_val("mid_drain_en", 64'(bus.o_pipe_en), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mrst_en",    64'(bus.o_pipe_en),   64'd0);
    check_val("mrst_ready", 64'(bus.o_cmd_ready), 64'd1);
    check_val("mrst_cnt",   64'(bus.o_cycle_cnt), 64'd0);
    tick();
    check_val("mrst_idle_en", 64'(bus.o_pipe_en), 64'd0);
    check_val("mrst_done",    64'(bus.o_done),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
